// File: rtl/vram_arbiter.sv
// vram_arbiter: shares a single-port synchronous frame-buffer RAM between
// VGA scan-out reads and buffered CPU pixel writes. Scan-out always wins a
// slot; queued CPU writes drain in every cycle without a display slot.
module vram_arbiter #(
   parameter int ADDR_W     = 15,
   parameter int DATA_W     = 8,
   parameter int FIFO_DEPTH = 4,
   parameter int FB_W       = 160,
   parameter int SCALE_SH   = 2
) (
   input  logic                        clk_50MHz,
   input  logic                        reset,
   input  logic                        pix_tick,
   input  logic                        video_on,
   input  logic [9:0]                  x,
   input  logic [9:0]                  y,
   input  logic                        cpu_we,
   input  logic [ADDR_W-1:0]           cpu_addr,
   input  logic [DATA_W-1:0]           cpu_wdata,
   output logic                        cpu_ready,
   output logic                        ovf,
   input  logic                        ovf_clr,
   output logic [$clog2(FIFO_DEPTH):0] fifo_level,
   output logic [ADDR_W-1:0]           mem_addr,
   output logic                        mem_we,
   output logic [DATA_W-1:0]           mem_wdata,
   input  logic [DATA_W-1:0]           mem_rdata,
   output logic [DATA_W-1:0]           pix_data
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam logic [PTR_W:0] FULL_LVL = (PTR_W+1)'(FIFO_DEPTH);
   localparam logic [PTR_W:0] ONE_LVL  = (PTR_W+1)'(1);
   localparam logic [PTR_W-1:0] ONE_PTR = PTR_W'(1);
   localparam logic [ADDR_W-1:0] FB_W_A = ADDR_W'(FB_W);

   // One-hot command kind for the RAM access issued in the next cycle.
   typedef enum logic [2:0] {
      IDLE = 3'b001,
      DISP = 3'b010,
      CPU  = 3'b100
   } state_t;

   state_t state_q, state_d;

   logic [ADDR_W+DATA_W-1:0] fifo_mem [FIFO_DEPTH];
   logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
   logic [PTR_W:0]    level_q, level_d;
   logic              ovf_q;
   logic              push, pop, slot;

   logic [ADDR_W-1:0] xq, yq, disp_addr;
   logic [ADDR_W-1:0] head_addr;
   logic [DATA_W-1:0] head_data;
   logic [ADDR_W-1:0] mem_addr_q;
   logic [DATA_W-1:0] mem_wdata_q;

   logic              slot_p0_q, slot_p1_q;
   logic              von_p0_q, von_p1_q;
   logic [DATA_W-1:0] pix_q;

   assign slot      = pix_tick & video_on;
   // Ready is judged on the start-of-cycle level, so a full FIFO rejects a
   // push even when a pop happens in the same cycle.
   assign cpu_ready = (level_q != FULL_LVL);
   assign push      = cpu_we & cpu_ready;

   assign {head_addr, head_data} = fifo_mem[rd_ptr_q];

   // Each stored pixel covers a 4x4 block on screen; for the 160-wide
   // buffer the row multiply reduces to two shifts and an add.
   assign xq        = ADDR_W'(x >> SCALE_SH);
   assign yq        = ADDR_W'(y >> SCALE_SH);
   assign disp_addr = (FB_W == 160) ? (yq << 7) + (yq << 5) + xq
                                    : yq * FB_W_A + xq;

   // Arbitration: a display slot always wins, otherwise drain the FIFO head.
   always_comb begin
      state_d = IDLE;
      pop     = 1'b0;
      if (slot) begin
         state_d = DISP;
      end else if (level_q != '0) begin
         state_d = CPU;
         pop     = 1'b1;
      end
   end

   // Occupancy update; simultaneous push and pop leaves the level unchanged.
   always_comb begin
      level_d = level_q;
      if (push && !pop) begin
         level_d = level_q + ONE_LVL;
      end else if (pop && !push) begin
         level_d = level_q - ONE_LVL;
      end
   end

   // FIFO storage carries no reset; validity is tracked by the pointers.
   always_ff @(posedge clk_50MHz) begin
      if (push) begin
         fifo_mem[wr_ptr_q] <= {cpu_addr, cpu_wdata};
      end
   end

   // FIFO pointers, occupancy and the sticky overflow flag (set beats clear).
   always_ff @(posedge clk_50MHz or posedge reset) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
         ovf_q    <= 1'b0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + ONE_PTR;
         if (pop)  rd_ptr_q <= rd_ptr_q + ONE_PTR;
         level_q <= level_d;
         if (cpu_we && !cpu_ready) begin
            ovf_q <= 1'b1;
         end else if (ovf_clr) begin
            ovf_q <= 1'b0;
         end
      end
   end

   // Registered RAM command; address and data hold while idle.
   always_ff @(posedge clk_50MHz or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
      end else begin
         state_q <= state_d;
         if (state_d == DISP) begin
            mem_addr_q <= disp_addr;
         end else if (state_d == CPU) begin
            mem_addr_q  <= head_addr;
            mem_wdata_q <= head_data;
         end
      end
   end

   // Read return path: slot and video_on ride alongside the RAM latency so
   // the pixel lands three edges after the slot, blanked outside display.
   always_ff @(posedge clk_50MHz or posedge reset) begin
      if (reset) begin
         slot_p0_q <= 1'b0;
         slot_p1_q <= 1'b0;
         von_p0_q  <= 1'b0;
         von_p1_q  <= 1'b0;
         pix_q     <= '0;
      end else begin
         slot_p0_q <= slot;
         slot_p1_q <= slot_p0_q;
         von_p0_q  <= video_on;
         von_p1_q  <= von_p0_q;
         if (!von_p1_q) begin
            pix_q <= '0;
         end else if (slot_p1_q) begin
            pix_q <= mem_rdata;
         end
      end
   end

   assign mem_we     = (state_q == CPU);
   assign mem_addr   = mem_addr_q;
   assign mem_wdata  = mem_wdata_q;
   assign ovf        = ovf_q;
   assign fifo_level = level_q;
   assign pix_data   = pix_q;

endmodule

// File: tb/tb_vram_arbiter.sv
// tb_vram_arbiter: directed scenarios plus randomized traffic checked
// against a queue-based reference model of the arbiter and frame buffer.
module tb_vram_arbiter;

   localparam int DEPTH = 4;

   logic        clk_50MHz = 1'b0;
   logic        reset     = 1'b1;
   logic        pix_tick  = 1'b0;
   logic        video_on  = 1'b0;
   logic [9:0]  x         = '0;
   logic [9:0]  y         = '0;
   logic        cpu_we    = 1'b0;
   logic [14:0] cpu_addr  = '0;
   logic [7:0]  cpu_wdata = '0;
   logic        cpu_ready;
   logic        ovf;
   logic        ovf_clr   = 1'b0;
   logic [2:0]  fifo_level;
   logic [14:0] mem_addr;
   logic        mem_we;
   logic [7:0]  mem_wdata;
   logic [7:0]  mem_rdata;
   logic [7:0]  pix_data;

   always #10 clk_50MHz = ~clk_50MHz;

   vram_arbiter dut (
      .clk_50MHz (clk_50MHz),
      .reset     (reset),
      .pix_tick  (pix_tick),
      .video_on  (video_on),
      .x         (x),
      .y         (y),
      .cpu_we    (cpu_we),
      .cpu_addr  (cpu_addr),
      .cpu_wdata (cpu_wdata),
      .cpu_ready (cpu_ready),
      .ovf       (ovf),
      .ovf_clr   (ovf_clr),
      .fifo_level(fifo_level),
      .mem_addr  (mem_addr),
      .mem_we    (mem_we),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata),
      .pix_data  (pix_data)
   );

   typedef struct packed {
      logic [14:0] a;
      logic [7:0]  d;
   } wr_t;

   logic [7:0] ram    [0:32767];
   logic [7:0] ref_fb [0:32767];
   wr_t        q[$];

   int         n_checks = 0;
   int         n_pass   = 0;

   logic       m_ovf, m_we;
   int         m_addr;
   logic [7:0] m_wdata, m_pix;
   logic       h0_von, h0_slot, h1_von, h1_slot;
   logic [7:0] h0_val, h1_val;

   function automatic logic [7:0] init_val(int i);
      if (i == 321)   return 8'hE0;
      if (i == 19199) return 8'h5A;
      return 8'((i * 37) ^ (i >> 4));
   endfunction

   // Behavioural single-port synchronous RAM: one-cycle read latency.
   initial begin
      for (int i = 0; i < 32768; i++) ram[i] = init_val(i);
      forever begin
         @(posedge clk_50MHz);
         if (mem_we) ram[mem_addr] <= mem_wdata;
         mem_rdata <= ram[mem_addr];
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   function automatic void model_reset();
      q.delete();
      m_ovf = 1'b0; m_we = 1'b0; m_addr = 0; m_wdata = '0; m_pix = '0;
      h0_von = 1'b0; h0_slot = 1'b0; h0_val = '0;
      h1_von = 1'b0; h1_slot = 1'b0; h1_val = '0;
   endfunction

   // Predicts the outputs after the coming clock edge from the current inputs.
   function automatic void model_step();
      int  sz;
      logic slot;
      wr_t e;
      sz   = q.size();
      slot = pix_tick && video_on;
      if (!h1_von)      m_pix = 8'h00;
      else if (h1_slot) m_pix = h1_val;
      h1_von = h0_von; h1_slot = h0_slot; h1_val = h0_val;
      h0_von = video_on; h0_slot = slot; h0_val = 8'h00;
      if (slot) begin
         m_we   = 1'b0;
         m_addr = (int'(y) / 4) * 160 + int'(x) / 4;
         h0_val = ref_fb[m_addr];
      end else if (sz > 0) begin
         e       = q.pop_front();
         m_we    = 1'b1;
         m_addr  = int'(e.a);
         m_wdata = e.d;
         ref_fb[e.a] = e.d;
      end else begin
         m_we = 1'b0;
      end
      if (cpu_we && sz < DEPTH) q.push_back('{a: cpu_addr, d: cpu_wdata});
      if (cpu_we && sz >= DEPTH) m_ovf = 1'b1;
      else if (ovf_clr)          m_ovf = 1'b0;
   endfunction

   task automatic check_all();
      chk("fifo_level", 32'(fifo_level), 32'(q.size()));
      chk("cpu_ready",  32'(cpu_ready),  32'(q.size() < DEPTH));
      chk("ovf",        32'(ovf),        32'(m_ovf));
      chk("mem_we",     32'(mem_we),     32'(m_we));
      chk("mem_addr",   32'(mem_addr),   32'(m_addr));
      chk("mem_wdata",  32'(mem_wdata),  32'(m_wdata));
      chk("pix_data",   32'(pix_data),   32'(m_pix));
   endtask

   task automatic step(input logic pt, input int xx, input int yy, input logic we,
                       input int a, input logic [7:0] d, input logic clr);
      pix_tick  = pt;
      x         = 10'(xx);
      y         = 10'(yy);
      video_on  = (xx < 640) && (yy < 480);
      cpu_we    = we;
      cpu_addr  = 15'(a);
      cpu_wdata = d;
      ovf_clr   = clr;
      model_step();
      @(posedge clk_50MHz);
      @(negedge clk_50MHz);
      check_all();
   endtask

   task automatic reset_checks(input string pfx);
      chk({pfx, "_level"}, 32'(fifo_level), 32'd0);
      chk({pfx, "_ready"}, 32'(cpu_ready),  32'd1);
      chk({pfx, "_we"},    32'(mem_we),     32'd0);
      chk({pfx, "_pix"},   32'(pix_data),   32'd0);
      chk({pfx, "_ovf"},   32'(ovf),        32'd0);
      chk({pfx, "_addr"},  32'(mem_addr),   32'd0);
   endtask

   task automatic slot_push();
      step(1'b1, $urandom_range(0, 639), $urandom_range(0, 479), 1'b1,
           $urandom_range(0, 19199), 8'($urandom), 1'b0);
   endtask

   initial begin
      for (int i = 0; i < 32768; i++) ref_fb[i] = init_val(i);
      model_reset();
      repeat (2) @(negedge clk_50MHz);
      reset_checks("rst_init");
      reset = 1'b0;

      // Queue three writes behind continuous slots, then reset mid-stream.
      for (int i = 0; i < 3; i++) slot_push();
      chk("t1_level_pre", 32'(fifo_level), 32'd3);
      pix_tick = 1'b0; cpu_we = 1'b0; video_on = 1'b0;
      reset = 1'b1;
      #3;
      reset_checks("t1_rst");
      model_reset();
      @(negedge clk_50MHz);
      reset = 1'b0;

      // Slot at (4,8) reads address 321 and shows E0 three edges later.
      step(1'b1, 4, 8, 1'b0, 0, 8'h00, 1'b0);
      chk("t2_addr", 32'(mem_addr), 32'd321);
      chk("t2_we",   32'(mem_we),   32'd0);
      step(1'b0, 100, 100, 1'b0, 0, 8'h00, 1'b0);
      step(1'b0, 100, 100, 1'b0, 0, 8'h00, 1'b0);
      chk("t2_pix",  32'(pix_data), 32'hE0);

      // Last display pixel, then an off-screen tick that must not read.
      step(1'b1, 639, 479, 1'b0, 0, 8'h00, 1'b0);
      chk("t3_addr_max", 32'(mem_addr), 32'd19199);
      step(1'b1, 640, 479, 1'b0, 0, 8'h00, 1'b0);
      chk("t3_no_read_we",   32'(mem_we),   32'd0);
      chk("t3_no_read_addr", 32'(mem_addr), 32'd19199);
      step(1'b0, 700, 479, 1'b0, 0, 8'h00, 1'b0);
      chk("t3_pix_last", 32'(pix_data), 32'h5A);
      step(1'b0, 700, 479, 1'b0, 0, 8'h00, 1'b0);
      chk("t3_pix_blank", 32'(pix_data), 32'd0);

      // Fill the FIFO, then a rejected push that coincides with a pop.
      for (int i = 0; i < 4; i++) slot_push();
      chk("t5_full_level", 32'(fifo_level), 32'd4);
      chk("t5_full_ready", 32'(cpu_ready),  32'd0);
      step(1'b0, 100, 100, 1'b1, 1234, 8'h77, 1'b0);
      chk("t5_rej_level", 32'(fifo_level), 32'd3);
      chk("t5_rej_ovf",   32'(ovf),        32'd1);
      slot_push();
      step(1'b1, 200, 200, 1'b1, 99, 8'h11, 1'b1);
      chk("t5_set_wins", 32'(ovf), 32'd1);
      step(1'b1, 200, 200, 1'b0, 0, 8'h00, 1'b1);
      chk("t5_clr", 32'(ovf), 32'd0);

      // Four queued writes drained only in the gaps between alternate slots.
      repeat (6) step(1'b0, 100, 100, 1'b0, 0, 8'h00, 1'b0);
      for (int i = 0; i < 4; i++) slot_push();
      chk("t4_level_full", 32'(fifo_level), 32'd4);
      for (int i = 0; i < 8; i++)
         step(i % 2 == 0, $urandom_range(0, 639), $urandom_range(0, 479), 1'b0, 0, 8'h00, 1'b0);
      chk("t4_level_empty", 32'(fifo_level), 32'd0);

      // Continuous writes across a blanking line, ready respected.
      for (int i = 0; i < 200; i++)
         step(1'b0, 700, 490, q.size() < DEPTH, $urandom_range(0, 19199), 8'($urandom), 1'b0);
      chk("t6_level", 32'(fifo_level), 32'd1);
      chk("t6_ovf",   32'(ovf),        32'd0);
      chk("t6_we",    32'(mem_we),     32'd1);

      // Randomized traffic over the whole raster.
      for (int i = 0; i < 3000; i++)
         step(1'($urandom % 2), $urandom_range(0, 799), $urandom_range(0, 524),
              ($urandom % 4) != 0, $urandom_range(0, 19199), 8'($urandom),
              ($urandom % 16) == 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
